// File: rtl/fifo_multiplier_stream_pkg.sv
// Shared definitions for the FIFO-fed multiplier stream: arithmetic mode encoding and
// width helpers used by the interface, the operand FIFO and the top level.
package fifo_multiplier_stream_pkg;

  typedef enum int {
    MODE_UNSIGNED = 0,
    MODE_SIGNED   = 1
  } mult_mode_e;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_multiplier_stream_if.sv
// Operand-in / product-out bundle of the multiplier stream; the block is the slave,
// the operand producer and product consumer together form the master side.
interface fifo_multiplier_stream_if
  import fifo_multiplier_stream_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8
) ();

  localparam int CW = count_width(DEPTH);

  logic              write_req;
  logic [2*W-1:0]    fifo_write_data;
  logic [CW-1:0]     left_sig;
  logic              overflow_sig;
  logic [2*W-1:0]    product;
  logic              product_valid;
  logic              product_ready;

  modport slave (
    input  write_req, fifo_write_data, product_ready,
    output left_sig, overflow_sig, product, product_valid
  );

  modport master (
    output write_req, fifo_write_data, product_ready,
    input  left_sig, overflow_sig, product, product_valid
  );

endinterface

// File: rtl/fifo_multiplier_stream_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: the head entry is visible on rdata_o while
// not empty; writes while full and pops while empty are ignored.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         write_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_write, do_pop;

  assign do_write = write_i && !full_o;
  assign do_pop   = pop_i && !empty_o;

  // NOTE: blocking assignments in combinational processes, non-blocking in clocked ones.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_write) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count and pointers decide which words are live.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/fifo_multiplier_stream.sv
// Operand FIFO feeding a PIPE_STAGES-deep multiplier pipeline with a single global
// advance enable; the last stage is the registered product/product_valid output.
module fifo_multiplier_stream
  import fifo_multiplier_stream_pkg::*;
#(
  parameter int W           = 8,
  parameter int DEPTH       = 8,
  parameter int PIPE_STAGES = 3,
  parameter int SIGNED      = MODE_UNSIGNED
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fifo_multiplier_stream_if.slave  bus
);

  localparam int PW = 2 * W;
  localparam int CW = count_width(DEPTH);

  logic [PW-1:0] head;
  logic          empty, full;
  logic [CW-1:0] count;
  logic          advance, pop;
  logic [PW-1:0] a_ext, b_ext, mult;

  logic [PIPE_STAGES-1:0][PW-1:0] prod_q, prod_d;
  logic [PIPE_STAGES-1:0]         vld_q, vld_d;
  logic                           ovf_q, ovf_d;

  // A stalled output freezes the whole pipe, including the FIFO read side.
  assign advance = !vld_q[PIPE_STAGES-1] || bus.product_ready;
  assign pop     = advance && !empty;

  sync_fifo_fwft #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .write_i (bus.write_req),
    .wdata_i (bus.fifo_write_data),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

  // Extending to the full product width keeps the low 2*W bits correct in both modes.
  always_comb begin
    if (SIGNED == MODE_SIGNED) begin
      a_ext = {{W{head[PW-1]}}, head[PW-1:W]};
      b_ext = {{W{head[W-1]}},  head[W-1:0]};
    end else begin
      a_ext = {{W{1'b0}}, head[PW-1:W]};
      b_ext = {{W{1'b0}}, head[W-1:0]};
    end
    mult = a_ext * b_ext;
  end

  always_comb begin
    prod_d = prod_q;
    vld_d  = vld_q;
    if (advance) begin
      vld_d[0]  = pop;
      prod_d[0] = mult;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        vld_d[i]  = vld_q[i-1];
        prod_d[i] = prod_q[i-1];
      end
    end
    ovf_d = ovf_q || (bus.write_req && full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      vld_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.product       = prod_q[PIPE_STAGES-1];
  assign bus.product_valid = vld_q[PIPE_STAGES-1];
  assign bus.left_sig      = CW'(DEPTH) - count;
  assign bus.overflow_sig  = ovf_q;

endmodule

// File: tb/tb_fifo_multiplier_stream.sv
// Scoreboard bench: an unsigned and a signed instance share one stimulus stream and are
// compared against an occupancy/latency reference model and an expected-product queue.
module tb_fifo_multiplier_stream;
  import fifo_multiplier_stream_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int P     = 3;
  localparam int PW    = 2 * W;

  typedef struct {
    logic [PW-1:0] pu;
    logic [PW-1:0] ps;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  fifo_multiplier_stream_if #(.W(W), .DEPTH(DEPTH)) bus_u ();
  fifo_multiplier_stream_if #(.W(W), .DEPTH(DEPTH)) bus_s ();

  fifo_multiplier_stream #(.W(W), .DEPTH(DEPTH), .PIPE_STAGES(P), .SIGNED(MODE_UNSIGNED)) dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_u)
  );

  fifo_multiplier_stream #(.W(W), .DEPTH(DEPTH), .PIPE_STAGES(P), .SIGNED(MODE_SIGNED)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  assign bus_s.write_req       = bus_u.write_req;
  assign bus_s.fifo_write_data = bus_u.fifo_write_data;
  assign bus_s.product_ready   = bus_u.product_ready;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t ref_mul(input logic [PW-1:0] d);
    exp_t r;
    int   a_u, b_u, a_s, b_s;
    logic signed [W-1:0] sa, sb;
    a_u  = int'(d[PW-1:W]);
    b_u  = int'(d[W-1:0]);
    sa   = d[PW-1:W];
    sb   = d[W-1:0];
    a_s  = int'(sa);
    b_s  = int'(sb);
    r.pu = PW'(a_u * b_u);
    r.ps = PW'(a_s * b_s);
    return r;
  endfunction

  // Reference model: occupancy count, P-cycle valid delay line gated by the global advance,
  // sticky overflow, and the expected products in acceptance order.
  logic [P-1:0] m_vld;
  int           m_occ;
  logic         m_ovf;
  exp_t         exp_q[$];
  logic         m_adv, m_pop, m_wr;

  assign m_adv = !m_vld[P-1] || bus_u.product_ready;
  assign m_pop = m_adv && (m_occ > 0);
  assign m_wr  = bus_u.write_req && (m_occ < DEPTH);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= '0;
      m_occ <= 0;
      m_ovf <= 1'b0;
      exp_q.delete();
    end else begin
      if (m_adv) m_vld <= {m_vld[P-2:0], m_pop};
      m_occ <= m_occ + int'(m_wr) - int'(m_pop);
      if (bus_u.write_req && m_occ >= DEPTH) m_ovf <= 1'b1;
      if (m_wr) exp_q.push_back(ref_mul(bus_u.fifo_write_data));
    end
  end

  // Monitor: samples on the falling edge, away from input changes and state updates.
  initial begin
    logic          hold_pend;
    logic [PW-1:0] hu, hs;
    exp_t          e;
    hold_pend = 1'b0;
    hu = '0;
    hs = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
        continue;
      end
      check("left_u", 32'(bus_u.left_sig), 32'(DEPTH - m_occ));
      check("left_s", 32'(bus_s.left_sig), 32'(DEPTH - m_occ));
      check("ovf_u", 32'(bus_u.overflow_sig), 32'(m_ovf));
      check("ovf_s", 32'(bus_s.overflow_sig), 32'(m_ovf));
      check("valid_u", 32'(bus_u.product_valid), 32'(m_vld[P-1]));
      check("valid_s", 32'(bus_s.product_valid), 32'(m_vld[P-1]));
      if (hold_pend) begin
        check("hold_u", 32'(bus_u.product), 32'(hu));
        check("hold_s", 32'(bus_s.product), 32'(hs));
      end
      hold_pend = 1'b0;
      if (bus_u.product_valid && !bus_u.product_ready) begin
        hold_pend = 1'b1;
        hu = bus_u.product;
        hs = bus_s.product;
      end
      if (bus_u.product_valid && bus_u.product_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_product: got %0h, expected no product", bus_u.product);
        end else begin
          e = exp_q.pop_front();
          check("prod_u", 32'(bus_u.product), 32'(e.pu));
          check("prod_s", 32'(bus_s.product), 32'(e.ps));
        end
      end
    end
  end

  task automatic drive(input logic req, input logic [PW-1:0] d, input logic rdy);
    @(posedge clk);
    #1;
    bus_u.write_req       = req;
    bus_u.fifo_write_data = d;
    bus_u.product_ready   = rdy;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus_u.product_valid | bus_s.product_valid), 32'd0);
    check({tag, "_left"},  32'(bus_u.left_sig), 32'(DEPTH));
    check({tag, "_ovf"},   32'(bus_u.overflow_sig | bus_s.overflow_sig), 32'd0);
    check({tag, "_prod"},  32'(bus_u.product | bus_s.product), 32'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_vld != '0) && n < 100) begin
      drive(1'b0, '0, 1'b1);
      n++;
    end
    drive(1'b0, '0, 1'b1);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    bus_u.write_req       = 1'b0;
    bus_u.fifo_write_data = '0;
    bus_u.product_ready   = 1'b0;
    #12;
    check_reset_outputs("reset");
    #5 rst_n = 1'b1;

    // Single pair into an empty FIFO: latency and value.
    drive(1'b1, {8'd12, 8'd10}, 1'b1);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      bus_u.write_req = 1'b0;
      if (bus_u.product_valid) begin
        lat = n;
        break;
      end
    end
    check("latency", 32'(lat), 32'(P + 1));
    check("first_product", 32'(bus_u.product), 32'd120);
    drain("single");

    // Continuous burst at full throughput.
    for (int i = 1; i <= 8; i++) drive(1'b1, {8'(i), 8'd3}, 1'b1);
    drain("burst");

    // Stalled output: pipe and FIFO fill, further writes overflow.
    for (int i = 0; i < 14; i++) drive(1'b1, 16'($urandom), 1'b0);
    drive(1'b0, '0, 1'b0);
    check("full_left", 32'(bus_u.left_sig), 32'd0);
    check("overflow_set", 32'(bus_u.overflow_sig), 32'd1);
    drain("stall");

    // Signed corner operands.
    drive(1'b1, 16'hFD07, 1'b1);
    drive(1'b1, 16'h8080, 1'b1);
    drive(1'b1, 16'h7F80, 1'b1);
    drive(1'b1, 16'hFFFF, 1'b1);
    drain("signed");

    // Ready toggling every cycle, then fully random traffic.
    for (int i = 0; i < 100; i++) drive($urandom_range(0, 3) != 0, 16'($urandom), 1'(i % 2));
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 2) != 0);
    drain("random");

    // Reset mid-stream with the FIFO partly occupied.
    for (int i = 0; i < 7; i++) drive(1'b1, 16'($urandom), 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus_u.write_req = 1'b0;
    #1;
    check_reset_outputs("midreset");
    #10 rst_n = 1'b1;
    for (int i = 0; i < 40; i++)
      drive($urandom_range(0, 1) != 0, 16'($urandom), $urandom_range(0, 3) != 0);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
